// File: rtl/debounce_pkg.sv
// debounce_pkg: state encoding and counter sizing shared by the debouncer
package debounce_pkg;

  localparam logic [1:0] STABLE_LOW  = 2'd0;
  localparam logic [1:0] PEND_HIGH   = 2'd1;
  localparam logic [1:0] STABLE_HIGH = 2'd2;
  localparam logic [1:0] PEND_LOW    = 2'd3;

  // The counter only ever holds 0..cycles-1, so clog2(cycles) bits suffice
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// edge_pulse: registered one-cycle rise/fall pulses from the next and current debounced level
module edge_pulse (
  input  logic clock,
  input  logic i_rst,
  input  logic level_next,
  input  logic level,
  output logic rise,
  output logic fall
);

  // A pulse is raised in the same cycle the registered level takes its new value
  always_ff @(posedge clock) begin
    if (i_rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= level_next & ~level;
      fall <= ~level_next & level;
    end
  end

endmodule

// File: rtl/debounce.sv
// debounce: level debouncer on a pre-synchronised input; DEBOUNCE_EDGE_EN enables rise/fall pulses
module debounce
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit INIT_LEVEL      = 1'b0
) (
  input  logic clock,
  input  logic i_rst,
  input  logic i_sync,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_glitch
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          level_n, glitch_n;

  // Next-state: a pending run either completes at LAST, extends, or is abandoned as a glitch
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    level_n  = o_level;
    glitch_n = 1'b0;
    case (state)
      STABLE_LOW:
        if (i_sync) begin
          state_n = PEND_HIGH;
          cnt_n   = CW'(1);
        end
      PEND_HIGH:
        if (!i_sync) begin
          state_n  = STABLE_LOW;
          cnt_n    = '0;
          glitch_n = 1'b1;
        end else if (cnt == LAST) begin
          state_n = STABLE_HIGH;
          cnt_n   = '0;
          level_n = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      STABLE_HIGH:
        if (!i_sync) begin
          state_n = PEND_LOW;
          cnt_n   = CW'(1);
        end
      PEND_LOW:
        if (i_sync) begin
          state_n  = STABLE_HIGH;
          cnt_n    = '0;
          glitch_n = 1'b1;
        end else if (cnt == LAST) begin
          state_n = STABLE_LOW;
          cnt_n   = '0;
          level_n = 1'b0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
    endcase
  end

  // State, counter and level/glitch registers; reset drops any pending change silently
  always_ff @(posedge clock) begin
    if (i_rst) begin
      state    <= INIT_LEVEL ? STABLE_HIGH : STABLE_LOW;
      cnt      <= '0;
      o_level  <= INIT_LEVEL;
      o_glitch <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      o_level  <= level_n;
      o_glitch <= glitch_n;
    end
  end

`ifdef DEBOUNCE_EDGE_EN
  edge_pulse u_edge_pulse (
    .clock      (clock),
    .i_rst      (i_rst),
    .level_next (level_n),
    .level      (o_level),
    .rise       (o_rise),
    .fall       (o_fall)
  );
`else
  assign o_rise = 1'b0;
  assign o_fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce.sv
// tb_debounce: scoreboard bench comparing two debouncer configurations against a run-length model
module tb_debounce;

  localparam int D0 = 4;
  localparam int D1 = 7;

  logic       clock = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_sync = 1'b0;
  logic [3:0] out0, out1;

  debounce #(.DEBOUNCE_CYCLES(D0), .INIT_LEVEL(1'b0)) dut0 (
    .clock(clock), .i_rst(i_rst), .i_sync(i_sync),
    .o_level(out0[3]), .o_rise(out0[2]), .o_fall(out0[1]), .o_glitch(out0[0])
  );

  debounce #(.DEBOUNCE_CYCLES(D1), .INIT_LEVEL(1'b1)) dut1 (
    .clock(clock), .i_rst(i_rst), .i_sync(i_sync),
    .o_level(out1[3]), .o_rise(out1[2]), .o_fall(out1[1]), .o_glitch(out1[0])
  );

  always #5 clock = ~clock;

  logic [3:0] q0[$];
  logic [3:0] q1[$];
  int compared = 0;
  int mismatched = 0;
  int cycle = 0;

  bit lvl[2];
  int run[2];
  int dc[2] = '{D0, D1};
  bit init[2] = '{1'b0, 1'b1};

  function automatic logic [3:0] step(int k, bit rst, bit s);
    bit r = 1'b0, f = 1'b0, g = 1'b0;
    if (rst) begin
      lvl[k] = init[k];
      run[k] = 0;
    end else if (s != lvl[k]) begin
      run[k]++;
      if (run[k] == dc[k]) begin
        lvl[k] = s;
        r = s;
        f = !s;
        run[k] = 0;
      end
    end else begin
      g = run[k] > 0;
      run[k] = 0;
    end
`ifndef DEBOUNCE_EDGE_EN
    r = 1'b0;
    f = 1'b0;
`endif
    return {lvl[k], r, f, g};
  endfunction

  task automatic drive(bit rst, bit s);
    @(negedge clock);
    i_rst  = rst;
    i_sync = s;
    q0.push_back(step(0, rst, s));
    q1.push_back(step(1, rst, s));
  endtask

  task automatic hold(bit rst, bit s, int n);
    for (int i = 0; i < n; i++) drive(rst, s);
  endtask

  task automatic check(string name, logic [3:0] got, logic [3:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s cycle %0d: got level/rise/fall/glitch=%b, expected %b", name, cycle, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      cycle++;
      if (q0.size() > 0) check("dut0", out0, q0.pop_front());
      if (q1.size() > 0) check("dut1", out1, q1.pop_front());
    end
  end

  initial begin
    hold(1, 1, 3);
    hold(0, 1, 9);
    hold(1, 0, 2);
    hold(0, 1, 3);
    hold(0, 0, 3);
    for (int i = 0; i < 20; i++) drive(0, (i % 2) == 0);
    hold(0, 0, 2);
    hold(0, 1, 8);
    hold(0, 0, 9);
    hold(0, 1, 2);
    drive(1, 1);
    hold(0, 1, 9);
    hold(0, 0, 3);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) hold(1, $urandom_range(0, 1), $urandom_range(1, 3));
      else hold(0, $urandom_range(0, 1), $urandom_range(1, 9));
    end
    hold(0, 0, 2);
    @(negedge clock);
    @(negedge clock);
    compared++;
    if (q0.size() + q1.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left, expected 0", q0.size() + q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
